inference_scheduler: RTL and testbench
======================================

INFERENCE_SCHEDULER -- requirements
Module: inference_scheduler

Interface
REQ-001 Parameters SHALL be: N_PIXELS, default 784, number of input pixels per image; N_CLASSES, default 10, number of output classes; INPUT_BASE, default 0, input-RAM base address; TIMEOUT_CYCLES, default 4096, maximum wait for network completion.
REQ-002 Clk  in  1  clock; all logic SHALL be on the rising edge.
REQ-003 Reset  in  1  synchronous, active-high reset.
REQ-004 Abort  in  1  synchronous request to return to IDLE.
REQ-005 Pix_Valid  in  1  pixel-stream valid; Pix_Data  in  16  pixel, unsigned Q3.13; Pix_Ready  out  1  scheduler accepts a pixel.
REQ-006 Wr_En  out  1, Wr_Addr  out  10, Wr_Data  out  16: write port to the input/output RAM.
REQ-007 Compute  out  1  network start, level; Nn_Done  in  1  network result-ready flag.
REQ-008 Probability  in  16 x N_CLASSES  network outputs, unsigned Q3.13.
REQ-009 Result_Valid  out  1, Result_Ready  in  1, Result_Digit  out  4, Result_Prob  out  16, Result_Error  out  1: result handshake.
REQ-010 Busy  out  1  high in every state except IDLE.

Function
REQ-011 States SHALL be IDLE, LOAD, LAUNCH, WAIT, ARGMAX and RESULT.
REQ-012 Pix_Ready SHALL be high only in IDLE and LOAD; a pixel transfers on a cycle with Pix_Valid and Pix_Ready both high.
REQ-013 A transfer in IDLE SHALL store pixel 0 and move to LOAD; each transfer SHALL increment a 10-bit pixel counter.
REQ-014 A transfer SHALL produce, one cycle later, Wr_En=1, Wr_Addr=INPUT_BASE+index and Wr_Data=the pixel; Wr_En SHALL be 0 otherwise.
REQ-015 The transfer of pixel N_PIXELS-1 SHALL move the FSM to LAUNCH; the counter SHALL wrap to 0.
REQ-016 LAUNCH SHALL last exactly 1 cycle with Compute low, which drains the final write, then move to WAIT.
REQ-017 Compute SHALL be high in every WAIT cycle and low in all other states.
REQ-018 In WAIT, Nn_Done=1 SHALL snapshot Probability into internal registers and move to ARGMAX.
REQ-019 The WAIT cycle counter SHALL start at 0 on entry; on reaching TIMEOUT_CYCLES without Nn_Done, the FSM SHALL go to RESULT with Result_Error=1, Result_Digit=4'hF and Result_Prob=0.
REQ-020 ARGMAX SHALL initialise best=index 0 and compare indices 1..N_CLASSES-1, one per cycle, using an unsigned strict greater-than, so ties keep the lower index.
REQ-021 If Nn_Done is sampled high in cycle T, Result_Valid SHALL first be high in cycle T+N_CLASSES, which is T+10 at the default.
REQ-022 In RESULT, Result_Valid SHALL be high, and Result_Digit, Result_Prob and Result_Error SHALL stay stable until a cycle with Result_Ready=1, after which the FSM moves to IDLE.
REQ-023 Result_Digit and Result_Prob SHALL be the index and value of the maximum; Result_Error SHALL be 0 on a normal completion.
REQ-024 Abort=1 SHALL move the FSM to IDLE at the next edge from any state: counters cleared, Compute low, no result produced; Abort SHALL take priority over Result_Ready and over a pixel transfer in the same cycle.
REQ-025 Pixels SHALL NOT be accepted, and Wr_En SHALL NOT be raised, outside IDLE/LOAD.
REQ-026 Nn_Done outside WAIT SHALL be ignored.

Reset
REQ-027 On Reset the FSM SHALL be in IDLE and all counters 0.
REQ-028 On Reset Pix_Ready=1, and Wr_En, Wr_Addr, Wr_Data, Compute, Result_Valid, Result_Digit, Result_Prob, Result_Error and Busy SHALL all be 0.
REQ-029 Reset SHALL dominate Abort, and Reset mid-operation SHALL discard the partial image and any pending result.

Structure
REQ-030 The state enum and the N_PIXELS, N_CLASSES and INPUT_BASE values SHALL live in the shared BRAM_ADDRS/constants package.
REQ-031 The block SHALL contain one sub-module, argmax_seq: sequential argmax over the snapshot registers with start/done and index/value outputs.
REQ-032 The block SHALL instantiate no RAM; it drives the existing RAM write port and the network's Compute input.

Verification
REQ-033 Stream 784 pixels with value k*8 at full rate -> 784 writes with Wr_Addr 0..783 matching the data, one LAUNCH cycle, then Compute high.
REQ-034 Nn_Done at cycle T with Probability[7]=0x1F00 and all others below it -> Result_Valid at T+10, Digit=7, Prob=0x1F00, Error=0.
REQ-035 Probability[2] and Probability[5] both 0x2000 as the maximum -> Digit=2.
REQ-036 Nn_Done never asserted -> Result_Error=1 and Digit=4'hF after 4096 WAIT cycles, with Compute low from then on.
REQ-037 Result_Ready held low for 20 cycles -> outputs stable throughout; Ready=1 -> IDLE and Pix_Ready=1 next cycle.
REQ-038 Abort at pixel 300 -> IDLE, with the next image written starting from Wr_Addr 0; Reset asserted in WAIT -> all outputs at their reset values next cycle.

Source files
------------

// File: rtl/inference_scheduler_pkg.sv
// Shared constants and state encoding for the inference scheduler and its argmax helper.
package inference_scheduler_pkg;
  localparam int N_PIXELS_DEF   = 784;
  localparam int N_CLASSES_DEF  = 10;
  localparam int INPUT_BASE_DEF = 0;
  localparam int TIMEOUT_DEF    = 4096;
  localparam int ADDR_W         = 10;
  localparam int PIX_W          = 16;
  localparam int IDX_W          = 4;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_LAUNCH = 3'd2,
    ST_WAIT   = 3'd3,
    ST_ARGMAX = 3'd4,
    ST_RESULT = 3'd5
  } sched_state_e;

  function automatic logic [ADDR_W-1:0] pixel_addr(input logic [ADDR_W-1:0] base,
                                                   input logic [ADDR_W-1:0] idx);
    return base + idx;
  endfunction
endpackage

// File: rtl/inference_scheduler_argmax_seq.sv
// Sequential argmax: after start_i, compares one class per cycle against the running best
// (strict greater-than, so ties keep the lower index) and flags done on the last class.
module argmax_seq
  import inference_scheduler_pkg::*;
#(
  parameter int N_CLASSES = N_CLASSES_DEF
) (
  input  logic                         Clk,
  input  logic                         Reset,
  input  logic                         clear_i,
  input  logic                         start_i,
  input  logic [PIX_W*N_CLASSES-1:0]   snap_i,
  output logic                         done_o,
  output logic [IDX_W-1:0]             idx_o,
  output logic [PIX_W-1:0]             val_o
);
  localparam logic [IDX_W-1:0] FIRST_IDX = IDX_W'(1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N_CLASSES - 1);

  logic             active_q, active_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] best_idx_q, best_idx_d;
  logic [PIX_W-1:0] best_val_q, best_val_d;
  logic [IDX_W-1:0] base_idx;
  logic [PIX_W-1:0] base_val;
  logic [PIX_W-1:0] cand_val;
  logic             take;

  // The first comparison uses class 0 directly as the incumbent best.
  always_comb begin
    base_idx = (idx_q == FIRST_IDX) ? {IDX_W{1'b0}} : best_idx_q;
    base_val = (idx_q == FIRST_IDX) ? snap_i[PIX_W-1:0] : best_val_q;
    cand_val = snap_i[int'(idx_q)*PIX_W +: PIX_W];
    take     = (cand_val > base_val);
    idx_o    = take ? idx_q : base_idx;
    val_o    = take ? cand_val : base_val;
    done_o   = active_q && (idx_q == LAST_IDX);
  end

  always_comb begin
    active_d   = active_q;
    idx_d      = idx_q;
    best_idx_d = best_idx_q;
    best_val_d = best_val_q;
    if (clear_i) begin
      active_d = 1'b0;
      idx_d    = {IDX_W{1'b0}};
    end else if (start_i) begin
      active_d = 1'b1;
      idx_d    = FIRST_IDX;
    end else if (active_q) begin
      best_idx_d = idx_o;
      best_val_d = val_o;
      if (done_o) begin
        active_d = 1'b0;
        idx_d    = {IDX_W{1'b0}};
      end else begin
        idx_d = idx_q + IDX_W'(1);
      end
    end else begin
      active_d = 1'b0;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      active_q   <= 1'b0;
      idx_q      <= {IDX_W{1'b0}};
      best_idx_q <= {IDX_W{1'b0}};
      best_val_q <= {PIX_W{1'b0}};
    end else begin
      active_q   <= active_d;
      idx_q      <= idx_d;
      best_idx_q <= best_idx_d;
      best_val_q <= best_val_d;
    end
  end
endmodule

// File: rtl/inference_scheduler.sv
// Inference scheduler: streams one image into the input RAM, starts the network, waits
// (with timeout) for its result and reports the most probable class via valid/ready.
module inference_scheduler
  import inference_scheduler_pkg::*;
#(
  parameter int N_PIXELS       = N_PIXELS_DEF,
  parameter int N_CLASSES      = N_CLASSES_DEF,
  parameter int INPUT_BASE     = INPUT_BASE_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEF
) (
  input  logic                       Clk,
  input  logic                       Reset,
  input  logic                       Abort_i,
  input  logic                       Pix_Valid_i,
  input  logic [PIX_W-1:0]           Pix_Data_i,
  output logic                       Pix_Ready_o,
  output logic                       Wr_En_o,
  output logic [ADDR_W-1:0]          Wr_Addr_o,
  output logic [PIX_W-1:0]           Wr_Data_o,
  output logic                       Compute_o,
  input  logic                       Nn_Done_i,
  input  logic [PIX_W*N_CLASSES-1:0] Probability_i,
  output logic                       Result_Valid_o,
  input  logic                       Result_Ready_i,
  output logic [IDX_W-1:0]           Result_Digit_o,
  output logic [PIX_W-1:0]           Result_Prob_o,
  output logic                       Result_Error_o,
  output logic                       Busy_o
);
  localparam int                WAIT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(INPUT_BASE);
  localparam logic [ADDR_W-1:0] PIX_LAST  = ADDR_W'(N_PIXELS - 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);

  sched_state_e               state_q, state_d;
  logic [ADDR_W-1:0]          pix_cnt_q, pix_cnt_d;
  logic [WAIT_W-1:0]          wait_cnt_q, wait_cnt_d;
  logic                       wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]          wr_addr_q, wr_addr_d;
  logic [PIX_W-1:0]           wr_data_q, wr_data_d;
  logic [PIX_W*N_CLASSES-1:0] snap_q, snap_d;
  logic [IDX_W-1:0]           digit_q, digit_d;
  logic [PIX_W-1:0]           prob_q, prob_d;
  logic                       err_q, err_d;
  logic                       am_start;
  logic                       am_done;
  logic [IDX_W-1:0]           am_idx;
  logic [PIX_W-1:0]           am_val;

  argmax_seq #(.N_CLASSES(N_CLASSES)) u_argmax (
    .Clk     (Clk),
    .Reset   (Reset),
    .clear_i (Abort_i),
    .start_i (am_start),
    .snap_i  (snap_q),
    .done_o  (am_done),
    .idx_o   (am_idx),
    .val_o   (am_val)
  );

  assign Pix_Ready_o    = (state_q == ST_IDLE) || (state_q == ST_LOAD);
  assign Compute_o      = (state_q == ST_WAIT);
  assign Busy_o         = (state_q != ST_IDLE);
  assign Result_Valid_o = (state_q == ST_RESULT);
  assign Wr_En_o        = wr_en_q;
  assign Wr_Addr_o      = wr_addr_q;
  assign Wr_Data_o      = wr_data_q;
  assign Result_Digit_o = digit_q;
  assign Result_Prob_o  = prob_q;
  assign Result_Error_o = err_q;

  // Abort wins over every other event, including a pixel transfer or result handshake.
  always_comb begin
    state_d    = state_q;
    pix_cnt_d  = pix_cnt_q;
    wait_cnt_d = wait_cnt_q;
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    snap_d     = snap_q;
    digit_d    = digit_q;
    prob_d     = prob_q;
    err_d      = err_q;
    am_start   = 1'b0;
    if (Abort_i) begin
      state_d    = ST_IDLE;
      pix_cnt_d  = {ADDR_W{1'b0}};
      wait_cnt_d = {WAIT_W{1'b0}};
    end else begin
      case (state_q)
        ST_IDLE, ST_LOAD: begin
          if (Pix_Valid_i) begin
            wr_en_d   = 1'b1;
            wr_addr_d = pixel_addr(BASE_ADDR, pix_cnt_q);
            wr_data_d = Pix_Data_i;
            if (pix_cnt_q == PIX_LAST) begin
              pix_cnt_d = {ADDR_W{1'b0}};
              state_d   = ST_LAUNCH;
            end else begin
              pix_cnt_d = pix_cnt_q + ADDR_W'(1);
              state_d   = ST_LOAD;
            end
          end else begin
            state_d = state_q;
          end
        end
        ST_LAUNCH: begin
          wait_cnt_d = {WAIT_W{1'b0}};
          state_d    = ST_WAIT;
        end
        ST_WAIT: begin
          if (Nn_Done_i) begin
            snap_d     = Probability_i;
            am_start   = 1'b1;
            wait_cnt_d = {WAIT_W{1'b0}};
            state_d    = ST_ARGMAX;
          end else if (wait_cnt_q == WAIT_LAST) begin
            wait_cnt_d = {WAIT_W{1'b0}};
            digit_d    = 4'hF;
            prob_d     = {PIX_W{1'b0}};
            err_d      = 1'b1;
            state_d    = ST_RESULT;
          end else begin
            wait_cnt_d = wait_cnt_q + WAIT_W'(1);
          end
        end
        ST_ARGMAX: begin
          if (am_done) begin
            digit_d = am_idx;
            prob_d  = am_val;
            err_d   = 1'b0;
            state_d = ST_RESULT;
          end else begin
            state_d = ST_ARGMAX;
          end
        end
        ST_RESULT: begin
          if (Result_Ready_i) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_RESULT;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q    <= ST_IDLE;
      pix_cnt_q  <= {ADDR_W{1'b0}};
      wait_cnt_q <= {WAIT_W{1'b0}};
      wr_en_q    <= 1'b0;
      wr_addr_q  <= {ADDR_W{1'b0}};
      wr_data_q  <= {PIX_W{1'b0}};
      snap_q     <= {(PIX_W*N_CLASSES){1'b0}};
      digit_q    <= {IDX_W{1'b0}};
      prob_q     <= {PIX_W{1'b0}};
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pix_cnt_q  <= pix_cnt_d;
      wait_cnt_q <= wait_cnt_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      snap_q     <= snap_d;
      digit_q    <= digit_d;
      prob_q     <= prob_d;
      err_q      <= err_d;
    end
  end
endmodule

// File: tb/tb_inference_scheduler.sv
// Directed, scoreboard-based bench for inference_scheduler: RAM writes and results are
// predicted when stimulus is driven and compared when the DUT produces them.
module tb_inference_scheduler;
  logic         Clk = 1'b0;
  logic         Reset;
  logic         Abort;
  logic         Pix_Valid;
  logic [15:0]  Pix_Data;
  logic         Pix_Ready;
  logic         Wr_En;
  logic [9:0]   Wr_Addr;
  logic [15:0]  Wr_Data;
  logic         Compute;
  logic         Nn_Done;
  logic [159:0] Probability;
  logic         Result_Valid;
  logic         Result_Ready;
  logic [3:0]   Result_Digit;
  logic [15:0]  Result_Prob;
  logic         Result_Error;
  logic         Busy;

  int checks = 0;
  int errors = 0;
  logic [25:0] wr_q[$];
  logic [20:0] res_q[$];
  logic [15:0] probs[10];
  logic [20:0] exp_res;

  inference_scheduler dut (
    .Clk(Clk), .Reset(Reset), .Abort_i(Abort), .Pix_Valid_i(Pix_Valid), .Pix_Data_i(Pix_Data),
    .Pix_Ready_o(Pix_Ready), .Wr_En_o(Wr_En), .Wr_Addr_o(Wr_Addr), .Wr_Data_o(Wr_Data),
    .Compute_o(Compute), .Nn_Done_i(Nn_Done), .Probability_i(Probability),
    .Result_Valid_o(Result_Valid), .Result_Ready_i(Result_Ready), .Result_Digit_o(Result_Digit),
    .Result_Prob_o(Result_Prob), .Result_Error_o(Result_Error), .Busy_o(Busy)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Advance one cycle, then compare any RAM write against the oldest predicted transfer.
  task automatic tick();
    logic [25:0] w;
    @(posedge Clk);
    #1;
    if (wr_q.size() > 0) begin
      w = wr_q.pop_front();
      check("wr_en", Wr_En, 1);
      check("wr_addr", Wr_Addr, w[25:16]);
      check("wr_data", Wr_Data, w[15:0]);
    end else begin
      check("wr_idle", Wr_En, 0);
    end
  endtask

  task automatic stream(input int n, input bit ramp);
    for (int k = 0; k < n; k++) begin
      Pix_Valid = 1'b1;
      Pix_Data  = ramp ? 16'(k * 8) : 16'($urandom);
      check("pix_ready", Pix_Ready, 1);
      wr_q.push_back({10'(k), Pix_Data});
      tick();
    end
    Pix_Valid = 1'b0;
  endtask

  task automatic drive_probs();
    for (int i = 0; i < 10; i++) Probability[16*i +: 16] = probs[i];
  endtask

  function automatic logic [20:0] model_result();
    int best = 0;
    for (int i = 1; i < 10; i++) if (probs[i] > probs[best]) best = i;
    return {1'b0, 4'(best), probs[best]};
  endfunction

  task automatic check_result();
    exp_res = res_q.pop_front();
    check("res_valid", Result_Valid, 1);
    check("res_error", Result_Error, exp_res[20]);
    check("res_digit", Result_Digit, exp_res[19:16]);
    check("res_prob", Result_Prob, exp_res[15:0]);
  endtask

  task automatic wait_result();
    int n = 0;
    while (!Result_Valid && n < 50) begin
      tick();
      n++;
    end
    check_result();
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_pix_ready"}, Pix_Ready, 1);
    check({tag, "_wr_en"}, Wr_En, 0);
    check({tag, "_wr_addr"}, Wr_Addr, 0);
    check({tag, "_wr_data"}, Wr_Data, 0);
    check({tag, "_compute"}, Compute, 0);
    check({tag, "_valid"}, Result_Valid, 0);
    check({tag, "_digit"}, Result_Digit, 0);
    check({tag, "_prob"}, Result_Prob, 0);
    check({tag, "_error"}, Result_Error, 0);
    check({tag, "_busy"}, Busy, 0);
  endtask

  initial begin
    int n;
    Reset = 1'b1; Abort = 1'b0; Pix_Valid = 1'b0; Pix_Data = 16'h0000;
    Nn_Done = 1'b0; Result_Ready = 1'b0; Probability = '0;
    tick();
    tick();
    check_reset_vals("rst");
    Reset = 1'b0;

    // Nn_Done outside WAIT must be ignored.
    Nn_Done = 1'b1;
    tick();
    Nn_Done = 1'b0;
    check("idle_done_busy", Busy, 0);
    check("idle_done_compute", Compute, 0);

    // Image A: ramp pixels, pixel attempts outside LOAD, class 7 wins.
    stream(784, 1'b1);
    check("launch_compute", Compute, 0);
    check("launch_busy", Busy, 1);
    check("launch_pix_ready", Pix_Ready, 0);
    Pix_Valid = 1'b1;
    tick();
    check("wait_compute", Compute, 1);
    check("wait_pix_ready", Pix_Ready, 0);
    tick();
    Pix_Valid = 1'b0;
    for (int i = 0; i < 10; i++) probs[i] = 16'($urandom_range(0, 16'h1EFF));
    probs[7] = 16'h1F00;
    drive_probs();
    tick();
    tick();
    Nn_Done = 1'b1;
    res_q.push_back({1'b0, 4'd7, 16'h1F00});
    tick();
    Nn_Done = 1'b0;
    Probability = {5{32'hFFFF_FFFF}};
    for (int i = 1; i <= 9; i++) begin
      check("valid_early", Result_Valid, 0);
      tick();
    end
    check_result();
    for (int i = 0; i < 20; i++) begin
      tick();
      check("hold_valid", Result_Valid, 1);
      check("hold_digit", Result_Digit, exp_res[19:16]);
      check("hold_prob", Result_Prob, exp_res[15:0]);
      check("hold_error", Result_Error, exp_res[20]);
    end
    Result_Ready = 1'b1;
    tick();
    Result_Ready = 1'b0;
    check("ack_pix_ready", Pix_Ready, 1);
    check("ack_busy", Busy, 0);
    check("ack_valid", Result_Valid, 0);

    // Image B: tie between classes 2 and 5 keeps the lower index.
    stream(784, 1'b0);
    tick();
    for (int i = 0; i < 10; i++) probs[i] = 16'($urandom_range(0, 16'h1FFF));
    probs[2] = 16'h2000;
    probs[5] = 16'h2000;
    drive_probs();
    Nn_Done = 1'b1;
    res_q.push_back({1'b0, 4'd2, 16'h2000});
    tick();
    Nn_Done = 1'b0;
    wait_result();
    Result_Ready = 1'b1;
    tick();
    Result_Ready = 1'b0;

    // Image C: random probabilities checked against the reference argmax.
    stream(784, 1'b0);
    tick();
    for (int i = 0; i < 10; i++) probs[i] = 16'($urandom);
    drive_probs();
    tick();
    Nn_Done = 1'b1;
    res_q.push_back(model_result());
    tick();
    Nn_Done = 1'b0;
    wait_result();
    Result_Ready = 1'b1;
    tick();
    Result_Ready = 1'b0;

    // Abort on pixel 300 beats the transfer; the next image restarts at address 0.
    stream(300, 1'b0);
    Pix_Valid = 1'b1;
    Abort = 1'b1;
    tick();
    Abort = 1'b0;
    Pix_Valid = 1'b0;
    check("abort_pix_ready", Pix_Ready, 1);
    check("abort_busy", Busy, 0);

    // Same image then times out: 4096 Compute cycles, error result.
    stream(784, 1'b1);
    tick();
    res_q.push_back({1'b1, 4'hF, 16'h0000});
    n = 0;
    while (Compute && n < 5000) begin
      n++;
      tick();
    end
    check("timeout_cycles", n, 4096);
    check("timeout_compute", Compute, 0);
    check_result();
    Result_Ready = 1'b1;
    tick();
    Result_Ready = 1'b0;
    check("timeout_ack_compute", Compute, 0);
    check("timeout_ack_busy", Busy, 0);

    // Abort during ARGMAX (together with Ready) produces no result.
    stream(784, 1'b0);
    tick();
    Nn_Done = 1'b1;
    tick();
    Nn_Done = 1'b0;
    tick();
    tick();
    Abort = 1'b1;
    Result_Ready = 1'b1;
    tick();
    Abort = 1'b0;
    check("abort_am_busy", Busy, 0);
    check("abort_am_compute", Compute, 0);
    for (int i = 0; i < 15; i++) begin
      check("abort_am_valid", Result_Valid, 0);
      tick();
    end
    Result_Ready = 1'b0;

    // Reset in WAIT returns every output to its reset value.
    stream(784, 1'b1);
    tick();
    tick();
    check("pre_reset_compute", Compute, 1);
    Reset = 1'b1;
    tick();
    check_reset_vals("rst_wait");
    Reset = 1'b0;
    tick();
    check("post_reset_busy", Busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
